// File: rtl/id_decode_stage_pkg.sv
// Shared constants for the ID stage: instruction field layout and default widths.
package id_decode_stage_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 64;
  localparam int unsigned DEFAULT_REG_ADDR_WIDTH = 3;
  localparam int unsigned DEFAULT_INSTR_WIDTH    = 32;
  localparam int unsigned NUM_REGS               = 8;

  // Instruction field bit positions
  localparam int unsigned W_REG_BIT = 31;
  localparam int unsigned W_MEM_BIT = 30;
  localparam int unsigned RS1_HI    = 29;
  localparam int unsigned RS1_LO    = 27;
  localparam int unsigned RS2_HI    = 26;
  localparam int unsigned RS2_LO    = 24;
  localparam int unsigned RD_HI     = 23;
  localparam int unsigned RD_LO     = 21;

endpackage

// File: rtl/id_decode_stage_reg_file_2r1w.sv
// 2-read / 1-write register file with same-cycle write-through on both read ports.
module id_decode_stage_reg_file_2r1w
  import id_decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int unsigned DEPTH      = NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // Next-state: single write port, no hardwired zero register
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads with write-through so WB->ID needs no stall
  always_comb begin
    rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
    rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: register file, field decode, RAW hazard stall and stall counter.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH  = DEFAULT_REG_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH     = DEFAULT_INSTR_WIDTH,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_WIDTH-1:0]     instr,
  input  logic                       instr_valid,
  input  logic                       wb_en,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  input  logic                       ex_w_reg_en,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_w_reg,
  input  logic                       mem_w_reg_en,
  input  logic [REG_ADDR_WIDTH-1:0]  mem_w_reg,
  output logic                       w_reg_en,
  output logic                       w_mem_en,
  output logic [DATA_WIDTH-1:0]      r1_out,
  output logic [DATA_WIDTH-1:0]      r2_out,
  output logic [REG_ADDR_WIDTH-1:0]  w_reg_1,
  output logic                       stall,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  logic                      dec_w_reg_en;
  logic                      dec_w_mem_en;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      rs1_used;
  logic                      rs2_used;
  logic                      rs1_hz;
  logic                      rs2_hz;
  logic                      hz;
  logic                      unused_instr_bits;

  logic [STALL_CNT_WIDTH-1:0] stall_count_q;
  logic [STALL_CNT_WIDTH-1:0] stall_count_d;

  // Low instruction bits carry nothing this stage needs
  assign unused_instr_bits = ^instr[RD_LO-1:0];

  // Field decode and source-usage
  always_comb begin
    dec_w_reg_en = instr[W_REG_BIT];
    dec_w_mem_en = instr[W_MEM_BIT];
    rs1          = instr[RS1_HI:RS1_LO];
    rs2          = instr[RS2_HI:RS2_LO];
    rd           = instr[RD_HI:RD_LO];
    rs1_used     = dec_w_reg_en | dec_w_mem_en;
    rs2_used     = dec_w_mem_en;
  end

  id_decode_stage_reg_file_2r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH),
    .DEPTH      (NUM_REGS)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (r1_out),
    .rdata2 (r2_out)
  );

  // RAW hazard against in-flight EX and MEM writes; WB is covered by write-through
  always_comb begin
    rs1_hz = (ex_w_reg_en && (ex_w_reg == rs1)) || (mem_w_reg_en && (mem_w_reg == rs1));
    rs2_hz = (ex_w_reg_en && (ex_w_reg == rs2)) || (mem_w_reg_en && (mem_w_reg == rs2));
    hz     = instr_valid && ((rs1_used && rs1_hz) || (rs2_used && rs2_hz));
  end

  // ID/EX outputs: enables squashed into a bubble on stall or empty slot
  always_comb begin
    stall    = hz;
    w_reg_en = dec_w_reg_en && instr_valid && !hz;
    w_mem_en = dec_w_mem_en && instr_valid && !hz;
    w_reg_1  = rd;
  end

  // Saturating stall counter next-state
  always_comb begin
    stall_count_d = stall_count_q;
    if (hz && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
